// File: rtl/sram_arbiter_if.sv
// Wishbone B4 pipelined bus bundle between one master and one slave.
// The master view drives the request side; the slave view returns ack, stall and read data.
interface sram_arbiter_if #(
   parameter int AW = 19,
   parameter int DW = 16
);
   logic          cyc;
   logic          stb;
   logic          we;
   logic [1:0]    sel;
   logic [AW-1:0] adr;
   logic [DW-1:0] dat_wr;
   logic          ack;
   logic          stall;
   logic [DW-1:0] dat_rd;

   modport master (
      output cyc, stb, we, sel, adr, dat_wr,
      input  ack, stall, dat_rd
   );

   modport slave (
      input  cyc, stb, we, sel, adr, dat_wr,
      output ack, stall, dat_rd
   );
endinterface

// File: rtl/sram_arbiter.sv
// Round-robin arbiter sharing one pipelined Wishbone SRAM controller between two masters.
// Ownership lasts a whole cyc and is only handed over once every accepted transfer has been acked.
module sram_arbiter #(
   parameter int AW     = 19,
   parameter int DW     = 16,
   parameter int MAXOUT = 7
) (
   input  logic           clk_i,
   input  logic           reset_i,
   sram_arbiter_if.slave  m0,
   sram_arbiter_if.slave  m1,
   sram_arbiter_if.master s,
   output logic [1:0]     grant_o
);

   localparam int CW = $clog2(MAXOUT + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(MAXOUT);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN0 = 2'd1,
      OWN1 = 2'd2
   } state_t;

   state_t        state_reg, state_next;
   logic          last_reg, last_next;   // 1 = m1 was granted last
   logic [CW-1:0] count_reg, count_next;

   logic own0, own1, full, busy, accept;
   logic req_any, win1, release_now, rearb;
   state_t arb_state;

   assign own0    = (state_reg == OWN0);
   assign own1    = (state_reg == OWN1);
   assign full    = (count_reg == CNT_MAX);
   assign busy    = (count_reg != '0);
   assign grant_o = {own1, own0};

   assign m0.dat_rd = s.dat_rd;
   assign m1.dat_rd = s.dat_rd;

   // Slave side follows the owner combinationally; cyc stays up while acks drain.
   always_comb begin
      s.cyc    = 1'b0;
      s.stb    = 1'b0;
      s.we     = 1'b0;
      s.sel    = '0;
      s.adr    = '0;
      s.dat_wr = '0;
      m0.ack   = 1'b0;
      m0.stall = 1'b1;
      m1.ack   = 1'b0;
      m1.stall = 1'b1;
      if (own0) begin
         s.cyc    = m0.cyc | busy;
         s.stb    = m0.stb & m0.cyc & ~full;
         s.we     = m0.we;
         s.sel    = m0.sel;
         s.adr    = m0.adr;
         s.dat_wr = m0.dat_wr;
         m0.ack   = s.ack;
         m0.stall = s.stall | full;
      end else if (own1) begin
         s.cyc    = m1.cyc | busy;
         s.stb    = m1.stb & m1.cyc & ~full;
         s.we     = m1.we;
         s.sel    = m1.sel;
         s.adr    = m1.adr;
         s.dat_wr = m1.dat_wr;
         m1.ack   = s.ack;
         m1.stall = s.stall | full;
      end
   end

   assign accept = s.stb & ~s.stall;

   // An ack with nothing outstanding is a slave error and must not wrap the counter.
   always_comb begin
      count_next = count_reg;
      if (accept && !s.ack)
         count_next = count_reg + 1'b1;
      else if (s.ack && !accept && busy)
         count_next = count_reg - 1'b1;
   end

   always_comb begin
      req_any     = m0.cyc | m1.cyc;
      win1        = m1.cyc & (~m0.cyc | ~last_reg);
      arb_state   = !req_any ? IDLE : (win1 ? OWN1 : OWN0);
      release_now = ((own0 & ~m0.cyc) | (own1 & ~m1.cyc)) & (count_next == '0);
      rearb       = ~(own0 | own1) | release_now;
      state_next  = rearb ? arb_state : state_reg;
      last_next   = (rearb & req_any) ? win1 : last_reg;
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_reg <= IDLE;
         last_reg  <= 1'b1;
         count_reg <= '0;
      end else begin
         state_reg <= state_next;
         last_reg  <= last_next;
         count_reg <= count_next;
      end
   end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed vector bench for sram_arbiter: one vector per clock cycle, checked mid-cycle.
module tb_sram_arbiter;

   localparam int AW = 19;
   localparam int DW = 16;

   typedef struct {
      bit       rst, c0, s0, c1, s1, ack, stl;
      bit [1:0] grant;
      bit       scyc, sstb, a0, st0, a1, st1;
      bit [2:0] cnt;
   } vec_t;

   logic clk_i = 1'b0;
   logic reset_i;
   logic [1:0] grant_o;
   logic [AW-1:0] adr0, adr1;

   int n_vec  = 0;
   int n_fail = 0;
   vec_t tbl[$];

   sram_arbiter_if #(.AW(AW), .DW(DW)) m0_bus ();
   sram_arbiter_if #(.AW(AW), .DW(DW)) m1_bus ();
   sram_arbiter_if #(.AW(AW), .DW(DW)) s_bus ();

   sram_arbiter #(.AW(AW), .DW(DW), .MAXOUT(7)) dut (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .m0      (m0_bus.slave),
      .m1      (m1_bus.slave),
      .s       (s_bus.master),
      .grant_o (grant_o)
   );

   always #5 clk_i = ~clk_i;

   function automatic vec_t mk(input bit rst, c0, s0, c1, s1, ack, stl,
                               input bit [1:0] g,
                               input bit scyc, sstb, a0, st0, a1, st1,
                               input int cnt);
      vec_t v;
      v.rst = rst; v.c0 = c0; v.s0 = s0; v.c1 = c1; v.s1 = s1; v.ack = ack; v.stl = stl;
      v.grant = g; v.scyc = scyc; v.sstb = sstb;
      v.a0 = a0; v.st0 = st0; v.a1 = a1; v.st1 = st1;
      v.cnt = 3'(cnt);
      return v;
   endfunction

   function automatic vec_t idle_v(input bit c0, c1, ack);
      return mk(0, c0, 0, c1, 0, ack, 0, 2'b00, 0, 0, 0, 1, 0, 1, 0);
   endfunction

   task automatic run(input vec_t v, input string name);
      logic [10:0] act_ctl, exp_ctl;
      logic [69:0] act_bus, exp_bus;
      logic [DW-1:0] rd;
      @(posedge clk_i);
      #1;
      rd = 16'h1000 + 16'(n_vec);
      reset_i        = v.rst;
      m0_bus.cyc     = v.c0;  m0_bus.stb = v.s0;  m0_bus.we = 1'b1;
      m0_bus.sel     = 2'b11; m0_bus.adr = adr0;  m0_bus.dat_wr = 16'hA5A5;
      m1_bus.cyc     = v.c1;  m1_bus.stb = v.s1;  m1_bus.we = 1'b0;
      m1_bus.sel     = 2'b01; m1_bus.adr = adr1;  m1_bus.dat_wr = 16'h5A5A;
      s_bus.ack      = v.ack; s_bus.stall = v.stl; s_bus.dat_rd = rd;
      @(negedge clk_i);
      exp_ctl = {v.grant, v.scyc, v.sstb, v.a0, v.st0, v.a1, v.st1, v.cnt};
      act_ctl = {grant_o, s_bus.cyc, s_bus.stb, m0_bus.ack, m0_bus.stall,
                 m1_bus.ack, m1_bus.stall, dut.count_reg};
      case (v.grant)
         2'b01:   exp_bus = {1'b1, 2'b11, adr0, 16'hA5A5, rd, rd};
         2'b10:   exp_bus = {1'b0, 2'b01, adr1, 16'h5A5A, rd, rd};
         default: exp_bus = {1'b0, 2'b00, {AW{1'b0}}, 16'h0000, rd, rd};
      endcase
      act_bus = {s_bus.we, s_bus.sel, s_bus.adr, s_bus.dat_wr, m0_bus.dat_rd, m1_bus.dat_rd};
      n_vec++;
      if (act_ctl !== exp_ctl || act_bus !== exp_bus) begin
         n_fail++;
         $display("FAIL %s #%0d: ctl got %03h want %03h, bus got %018h want %018h",
                  name, n_vec, act_ctl, exp_ctl, act_bus, exp_bus);
      end else begin
         $display("ok   %s #%0d: grant=%b cnt=%0d", name, n_vec, grant_o, dut.count_reg);
      end
   endtask

   initial begin
      adr0 = 19'h00100;
      adr1 = 19'h00010;
      reset_i = 1'b1;
      m0_bus.cyc = 0; m0_bus.stb = 0; m0_bus.we = 0; m0_bus.sel = 0; m0_bus.adr = 0; m0_bus.dat_wr = 0;
      m1_bus.cyc = 0; m1_bus.stb = 0; m1_bus.we = 0; m1_bus.sel = 0; m1_bus.adr = 0; m1_bus.dat_wr = 0;
      s_bus.ack = 0; s_bus.stall = 0; s_bus.dat_rd = 0;
      @(posedge clk_i);

      // reset with both requesting, first grant, m1 with stall, spurious ack in IDLE
      tbl.push_back(mk(1, 1, 0, 1, 0, 0, 0, 2'b00, 0, 0, 0, 1, 0, 1, 0));
      tbl.push_back(mk(1, 1, 0, 1, 0, 0, 0, 2'b00, 0, 0, 0, 1, 0, 1, 0));
      tbl.push_back(mk(0, 1, 0, 1, 0, 0, 0, 2'b00, 0, 0, 0, 1, 0, 1, 0));
      tbl.push_back(mk(0, 1, 1, 1, 0, 0, 0, 2'b01, 1, 1, 0, 0, 0, 1, 0));
      tbl.push_back(mk(0, 1, 0, 1, 0, 1, 0, 2'b01, 1, 0, 1, 0, 0, 1, 1));
      tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 2'b01, 0, 0, 0, 0, 0, 1, 0));
      tbl.push_back(mk(0, 0, 0, 1, 1, 0, 1, 2'b10, 1, 1, 0, 1, 0, 1, 0));
      tbl.push_back(mk(0, 0, 0, 1, 1, 0, 0, 2'b10, 1, 1, 0, 1, 0, 0, 0));
      tbl.push_back(mk(0, 0, 0, 1, 1, 1, 0, 2'b10, 1, 1, 0, 1, 1, 0, 1));
      tbl.push_back(mk(0, 0, 0, 1, 0, 1, 0, 2'b10, 1, 0, 0, 1, 1, 0, 1));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 2'b10, 0, 0, 0, 1, 0, 0, 0));
      tbl.push_back(idle_v(0, 0, 1));
      tbl.push_back(idle_v(0, 0, 0));
      for (int i = 0; i < tbl.size(); i++) run(tbl[i], "table");

      // m1 alone: four pipelined reads, slave acks two cycles after accept
      run(idle_v(0, 1, 0), "single");
      for (int i = 0; i < 4; i++) begin
         adr1 = 19'h00010 + 19'(i);
         run(mk(0, 0, 0, 1, 1, i >= 2, 0, 2'b10, 1, 1, 0, 1, i >= 2, 0, (i == 0) ? 0 : ((i == 1) ? 1 : 2)), "single");
      end
      run(mk(0, 0, 0, 1, 0, 1, 0, 2'b10, 1, 0, 0, 1, 1, 0, 2), "single");
      run(mk(0, 0, 0, 0, 0, 1, 0, 2'b10, 1, 0, 0, 1, 1, 0, 1), "single");
      run(idle_v(0, 0, 0), "single");
      adr1 = 19'h00010;

      // round robin: grants m0, m1, m0, m1 with same-edge handover
      run(idle_v(1, 1, 0), "rr");
      for (int r = 0; r < 2; r++) begin
         run(mk(0, 1, 1, 1, 0, 0, 0, 2'b01, 1, 1, 0, 0, 0, 1, 0), "rr");
         run(mk(0, 1, 1, 1, 0, 1, 0, 2'b01, 1, 1, 1, 0, 0, 1, 1), "rr");
         run(mk(0, 0, 0, 1, 0, 1, 0, 2'b01, 1, 0, 1, 0, 0, 1, 1), "rr");
         run(mk(0, r == 0, 0, 1, 1, 0, 0, 2'b10, 1, 1, 0, 1, 0, 0, 0), "rr");
         run(mk(0, r == 0, 0, 1, 1, 1, 0, 2'b10, 1, 1, 0, 1, 1, 0, 1), "rr");
         run(mk(0, r == 0, 0, 0, 0, 1, 0, 2'b10, 1, 0, 0, 1, 1, 0, 1), "rr");
      end
      run(idle_v(0, 0, 0), "rr");

      // drain: m0 drops cyc with three outstanding while m1 waits
      run(idle_v(1, 1, 0), "drain");
      for (int k = 0; k < 3; k++)
         run(mk(0, 1, 1, 1, 0, 0, 0, 2'b01, 1, 1, 0, 0, 0, 1, k), "drain");
      run(mk(0, 0, 0, 1, 0, 0, 0, 2'b01, 1, 0, 0, 0, 0, 1, 3), "drain");
      for (int k = 3; k >= 1; k--)
         run(mk(0, 0, 0, 1, 0, 1, 0, 2'b01, 1, 0, 1, 0, 0, 1, k), "drain");
      run(mk(0, 0, 0, 1, 1, 0, 0, 2'b10, 1, 1, 0, 1, 0, 0, 0), "drain");
      run(mk(0, 0, 0, 0, 0, 1, 0, 2'b10, 1, 0, 0, 1, 1, 0, 1), "drain");
      run(idle_v(0, 0, 0), "drain");

      // backpressure: acks withheld, count saturates at 7
      run(mk(0, 1, 1, 0, 0, 0, 0, 2'b00, 0, 0, 0, 1, 0, 1, 0), "maxout");
      for (int k = 0; k < 7; k++)
         run(mk(0, 1, 1, 0, 0, 0, 0, 2'b01, 1, 1, 0, 0, 0, 1, k), "maxout");
      for (int k = 0; k < 2; k++)
         run(mk(0, 1, 1, 0, 0, 0, 0, 2'b01, 1, 0, 0, 1, 0, 1, 7), "maxout");
      run(mk(0, 1, 1, 0, 0, 1, 0, 2'b01, 1, 0, 1, 1, 0, 1, 7), "maxout");
      run(mk(0, 1, 1, 0, 0, 1, 0, 2'b01, 1, 1, 1, 0, 0, 1, 6), "maxout");
      run(mk(0, 1, 1, 0, 0, 0, 0, 2'b01, 1, 1, 0, 0, 0, 1, 6), "maxout");
      run(mk(0, 1, 0, 0, 0, 0, 0, 2'b01, 1, 0, 0, 1, 0, 1, 7), "maxout");
      for (int k = 7; k >= 1; k--)
         run(mk(0, 0, 0, 0, 0, 1, 0, 2'b01, 1, 0, 1, k == 7, 0, 1, k), "maxout");

      // tie after m0 was last granted goes to m1
      run(idle_v(1, 1, 0), "tie");
      run(mk(0, 0, 0, 0, 0, 0, 0, 2'b10, 0, 0, 0, 1, 0, 0, 0), "tie");
      run(idle_v(0, 0, 0), "tie");

      // reset mid-transfer discards outstanding count and pending acks
      run(mk(0, 1, 1, 0, 0, 0, 0, 2'b00, 0, 0, 0, 1, 0, 1, 0), "rstmid");
      run(mk(0, 1, 1, 0, 0, 0, 0, 2'b01, 1, 1, 0, 0, 0, 1, 0), "rstmid");
      run(mk(1, 1, 1, 0, 0, 0, 0, 2'b01, 1, 1, 0, 0, 0, 1, 1), "rstmid");
      run(idle_v(0, 0, 1), "rstmid");
      run(idle_v(0, 0, 0), "rstmid");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
